mccu_wait: RTL and testbench

- Next-generation multicycle MIPS control FSM. Drives the same datapath controls as the current multicycle CU.
- Adds a variable-latency memory handshake (mem_req/mem_ready) on fetch and data access.
- Adds a wait-cycle timeout and a precise exception state for undefined opcodes and bus timeouts; the exception state redirects PC to a vector and saves EPC/cause.
- Sits between the IR decode fields and the datapath muxes/register enables.

---
 rtl/mccu_wait_if.sv | 40 ++++
 rtl/mccu_wait.sv | 194 +++++++++++++++++++
 tb/tb_mccu_wait.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mccu_wait_if.sv
// Control-unit bundle between the mccu_wait FSM and the multicycle datapath:
// decode fields and memory handshake in, mux selects and register enables out.
interface mccu_wait_if #(
    parameter int PCSRC_W = 3
) ();
    logic [5:0]         op;
    logic [5:0]         func;
    logic               z;
    logic               mem_ready;
    logic               mem_req;
    logic               wpc;
    logic               wir;
    logic               wmem;
    logic               wreg;
    logic               iord;
    logic               regrt;
    logic               m2reg;
    logic               shift;
    logic               alusrca;
    logic               jal;
    logic               sext;
    logic [3:0]         aluc;
    logic [1:0]         alusrcb;
    logic [PCSRC_W-1:0] pcsource;
    logic               wepc;
    logic [1:0]         cause;
    logic [2:0]         state;

    modport master (
        input  op, func, z, mem_ready,
        output mem_req, wpc, wir, wmem, wreg, iord, regrt, m2reg, shift,
               alusrca, jal, sext, aluc, alusrcb, pcsource, wepc, cause, state
    );

    modport slave (
        output op, func, z, mem_ready,
        input  mem_req, wpc, wir, wmem, wreg, iord, regrt, m2reg, shift,
               alusrca, jal, sext, aluc, alusrcb, pcsource, wepc, cause, state
    );
endinterface

// File: rtl/mccu_wait.sv
// Multicycle MIPS control FSM with a waitable memory handshake, a bus-timeout
// counter and a one-cycle exception state that vectors the PC and saves EPC/cause.
module mccu_wait #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4,
    parameter int PCSRC_W = 3
) (
    input  logic        clock,
    input  logic        resetn,
    mccu_wait_if.master bus
);
    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EXE = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4,
        ST_EXC = 3'd5
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_UNDEF = 2'd1;
    localparam logic [1:0] CAUSE_BUS   = 2'd2;

    state_t           state_q, next_state;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       cause_q, next_cause;
    logic             timed_out;

    logic       is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_jalr;
    logic       is_shift, is_imm, is_limm, is_undef;
    logic [3:0] alu_op;

    always_comb begin
        {is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_jalr} = '0;
        {is_shift, is_imm, is_limm, is_undef} = '0;
        alu_op = 4'b0000;
        case (bus.op)
            6'b000000: begin
                case (bus.func)
                    6'b100000: alu_op = 4'b0000;
                    6'b100010: alu_op = 4'b0100;
                    6'b100100: alu_op = 4'b0001;
                    6'b100101: alu_op = 4'b0101;
                    6'b100110: alu_op = 4'b0010;
                    6'b100111: alu_op = 4'b1101;
                    6'b101010: alu_op = 4'b1000;
                    6'b000000: begin alu_op = 4'b0011; is_shift = 1'b1; end
                    6'b000010: begin alu_op = 4'b0111; is_shift = 1'b1; end
                    6'b000011: begin alu_op = 4'b1111; is_shift = 1'b1; end
                    6'b001000: is_jr   = 1'b1;
                    6'b001001: is_jalr = 1'b1;
                    default:   is_undef = 1'b1;
                endcase
            end
            6'b001000: begin alu_op = 4'b0000; is_imm = 1'b1; end
            6'b001100: begin alu_op = 4'b0001; is_imm = 1'b1; is_limm = 1'b1; end
            6'b001101: begin alu_op = 4'b0101; is_imm = 1'b1; is_limm = 1'b1; end
            6'b001110: begin alu_op = 4'b0010; is_imm = 1'b1; is_limm = 1'b1; end
            6'b001111: begin alu_op = 4'b0110; is_imm = 1'b1; end
            6'b001010: begin alu_op = 4'b1000; is_imm = 1'b1; end
            6'b100011: is_lw = 1'b1;
            6'b101011: is_sw = 1'b1;
            6'b000100: begin alu_op = 4'b0010; is_beq = 1'b1; end
            6'b000101: begin alu_op = 4'b0010; is_bne = 1'b1; end
            6'b000010: is_j   = 1'b1;
            6'b000011: is_jal = 1'b1;
            default:   is_undef = 1'b1;
        endcase
    end

    // Ready in the same cycle the counter hits TIMEOUT still completes the access.
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT)) && !bus.mem_ready;

    // resetn is active-high, so all controls sit at their defaults while it is asserted.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.wpc      = 1'b0;
        bus.wir      = 1'b0;
        bus.wmem     = 1'b0;
        bus.wreg     = 1'b0;
        bus.iord     = 1'b0;
        bus.regrt    = 1'b0;
        bus.m2reg    = 1'b0;
        bus.shift    = 1'b0;
        bus.alusrca  = 1'b0;
        bus.jal      = 1'b0;
        bus.sext     = 1'b1;
        bus.aluc     = 4'b0000;
        bus.alusrcb  = 2'd0;
        bus.pcsource = PCSRC_W'(0);
        bus.wepc     = 1'b0;
        bus.cause    = CAUSE_NONE;
        bus.state    = state_q;
        next_state   = ST_IF;
        next_cause   = cause_q;
        if (!resetn) begin
            case (state_q)
                ST_IF: begin
                    bus.mem_req = 1'b1;
                    bus.alusrca = 1'b1;
                    bus.alusrcb = 2'd1;
                    if (bus.mem_ready) begin
                        bus.wpc    = 1'b1;
                        bus.wir    = 1'b1;
                        next_state = ST_ID;
                    end else if (timed_out) begin
                        next_state = ST_EXC;
                        next_cause = CAUSE_BUS;
                    end else begin
                        next_state = ST_IF;
                    end
                end
                ST_ID: begin
                    if (is_undef) begin
                        next_state = ST_EXC;
                        next_cause = CAUSE_UNDEF;
                    end else if (is_j || is_jal) begin
                        bus.pcsource = PCSRC_W'(3);
                        bus.wpc      = 1'b1;
                        bus.jal      = is_jal;
                        bus.wreg     = is_jal;
                    end else if (is_jr || is_jalr) begin
                        bus.pcsource = PCSRC_W'(2);
                        bus.wpc      = 1'b1;
                        bus.jal      = is_jalr;
                        bus.wreg     = is_jalr;
                    end else begin
                        bus.alusrca = 1'b1;
                        bus.alusrcb = 2'd3;
                        next_state  = ST_EXE;
                    end
                end
                ST_EXE: begin
                    bus.aluc = alu_op;
                    if (is_beq || is_bne) begin
                        bus.pcsource = PCSRC_W'(1);
                        bus.wpc      = (is_beq && bus.z) || (is_bne && !bus.z);
                    end else if (is_lw || is_sw) begin
                        bus.alusrcb = 2'd2;
                        next_state  = ST_MEM;
                    end else begin
                        bus.shift = is_shift;
                        if (is_imm) bus.alusrcb = 2'd2;
                        bus.sext   = !is_limm;
                        next_state = ST_WB;
                    end
                end
                ST_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    bus.wmem    = is_sw;
                    if (bus.mem_ready) begin
                        next_state = is_sw ? ST_IF : ST_WB;
                    end else if (timed_out) begin
                        next_state = ST_EXC;
                        next_cause = CAUSE_BUS;
                    end else begin
                        next_state = ST_MEM;
                    end
                end
                ST_WB: begin
                    bus.wreg  = 1'b1;
                    bus.m2reg = is_lw;
                    bus.regrt = is_lw || is_imm;
                end
                ST_EXC: begin
                    bus.wepc     = 1'b1;
                    bus.cause    = cause_q;
                    bus.pcsource = PCSRC_W'(4);
                    bus.wpc      = 1'b1;
                end
                default: next_state = ST_IF;
            endcase
        end
    end

    // The wait counter restarts on any state change and saturates instead of wrapping.
    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q <= ST_IF;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= next_state;
            cause_q <= next_cause;
            if (next_state != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mccu_wait.sv
// Instruction-level reference bench for mccu_wait: each instruction is expanded
// into its expected per-cycle trace, then replayed against the DUT.
module tb_mccu_wait;
    localparam int TIMEOUT = 15;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    mccu_wait_if #(.PCSRC_W(3)) bus ();

    mccu_wait #(.TIMEOUT(TIMEOUT), .CNT_W(4), .PCSRC_W(3)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic       mem_req, wpc, wir, wmem, wreg, iord, regrt, m2reg;
        logic       shift, alusrca, jal, sext;
        logic [3:0] aluc;
        logic [1:0] alusrcb;
        logic [2:0] pcsource;
        logic       wepc;
        logic [1:0] cause;
    } ctl_t;

    typedef enum int {K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_JALR, K_UNDEF} kind_e;

    localparam logic [11:0] LEGAL [0:23] = '{
        12'b000000_100000, 12'b000000_100010, 12'b000000_100100, 12'b000000_100101,
        12'b000000_100110, 12'b000000_100111, 12'b000000_101010, 12'b000000_000000,
        12'b000000_000010, 12'b000000_000011, 12'b000000_001000, 12'b000000_001001,
        12'b001000_000000, 12'b001100_000000, 12'b001101_000000, 12'b001110_000000,
        12'b001111_000000, 12'b001010_000000, 12'b100011_000000, 12'b101011_000000,
        12'b000100_000000, 12'b000101_000000, 12'b000010_000000, 12'b000011_000000
    };

    int checks = 0;
    int errors = 0;

    int         exp_rdy[$];
    logic [2:0] exp_st[$];
    ctl_t       exp_ctl[$];

    function automatic ctl_t idleCtl();
        ctl_t c = '0;
        c.sext = 1'b1;
        return c;
    endfunction

    function automatic ctl_t excCtl(input logic [1:0] why);
        ctl_t c = idleCtl();
        c.wepc     = 1'b1;
        c.cause    = why;
        c.pcsource = 3'd4;
        c.wpc      = 1'b1;
        return c;
    endfunction

    function automatic ctl_t actualCtl();
        ctl_t c;
        c = '{bus.mem_req, bus.wpc, bus.wir, bus.wmem, bus.wreg, bus.iord, bus.regrt,
              bus.m2reg, bus.shift, bus.alusrca, bus.jal, bus.sext, bus.aluc,
              bus.alusrcb, bus.pcsource, bus.wepc, bus.cause};
        return c;
    endfunction

    // Instruction table straight from the ISA: class, ALU code and immediate flavour.
    function automatic void decodeRef(input logic [5:0] op, input logic [5:0] func,
                                      output kind_e k, output logic [3:0] alu,
                                      output logic imm, output logic limm, output logic sh);
        k = K_ALU; alu = 4'b0000; imm = 1'b0; limm = 1'b0; sh = 1'b0;
        case (op)
            6'b000000:
                case (func)
                    6'b100000: alu = 4'b0000;
                    6'b100010: alu = 4'b0100;
                    6'b100100: alu = 4'b0001;
                    6'b100101: alu = 4'b0101;
                    6'b100110: alu = 4'b0010;
                    6'b100111: alu = 4'b1101;
                    6'b101010: alu = 4'b1000;
                    6'b000000: begin alu = 4'b0011; sh = 1'b1; end
                    6'b000010: begin alu = 4'b0111; sh = 1'b1; end
                    6'b000011: begin alu = 4'b1111; sh = 1'b1; end
                    6'b001000: k = K_JR;
                    6'b001001: k = K_JALR;
                    default:   k = K_UNDEF;
                endcase
            6'b001000: begin alu = 4'b0000; imm = 1'b1; end
            6'b001100: begin alu = 4'b0001; imm = 1'b1; limm = 1'b1; end
            6'b001101: begin alu = 4'b0101; imm = 1'b1; limm = 1'b1; end
            6'b001110: begin alu = 4'b0010; imm = 1'b1; limm = 1'b1; end
            6'b001111: begin alu = 4'b0110; imm = 1'b1; end
            6'b001010: begin alu = 4'b1000; imm = 1'b1; end
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            6'b000100: begin k = K_BEQ; alu = 4'b0010; end
            6'b000101: begin k = K_BNE; alu = 4'b0010; end
            6'b000010: k = K_J;
            6'b000011: k = K_JAL;
            default:   k = K_UNDEF;
        endcase
    endfunction

    // rdy: 0 or 1 drives mem_ready to that value, 2 lets it float randomly.
    task automatic push(input int rdy, input logic [2:0] st, input ctl_t c);
        exp_rdy.push_back(rdy);
        exp_st.push_back(st);
        exp_ctl.push_back(c);
    endtask

    // A memory phase with 'waits' not-ready cycles; more than TIMEOUT waits ends in EXC.
    task automatic accessPhase(input logic [2:0] st, input int waits, input ctl_t waitCtl,
                               input ctl_t doneCtl, output bit ok);
        int n;
        n = (waits > TIMEOUT) ? TIMEOUT + 1 : waits;
        for (int i = 0; i < n; i++) push(0, st, waitCtl);
        if (waits > TIMEOUT) begin
            push(2, 3'd5, excCtl(2'd2));
            ok = 1'b0;
        end else begin
            push(1, st, doneCtl);
            ok = 1'b1;
        end
    endtask

    task automatic buildTrace(input logic [5:0] op, input logic [5:0] func, input logic z,
                              input int fw, input int mw);
        kind_e      k;
        logic [3:0] alu;
        logic       imm, limm, sh;
        bit         ok;
        ctl_t       c, cw, cd;
        decodeRef(op, func, k, alu, imm, limm, sh);
        cw = idleCtl();
        cw.mem_req = 1'b1; cw.alusrca = 1'b1; cw.alusrcb = 2'd1;
        cd = cw;
        cd.wpc = 1'b1; cd.wir = 1'b1;
        accessPhase(3'd0, fw, cw, cd, ok);
        if (!ok) return;
        c = idleCtl();
        case (k)
            K_UNDEF: begin
                push(2, 3'd1, c);
                push(2, 3'd5, excCtl(2'd1));
            end
            K_J, K_JAL: begin
                c.pcsource = 3'd3; c.wpc = 1'b1;
                c.jal = (k == K_JAL); c.wreg = (k == K_JAL);
                push(2, 3'd1, c);
            end
            K_JR, K_JALR: begin
                c.pcsource = 3'd2; c.wpc = 1'b1;
                c.jal = (k == K_JALR); c.wreg = (k == K_JALR);
                push(2, 3'd1, c);
            end
            default: begin
                c.alusrca = 1'b1; c.alusrcb = 2'd3;
                push(2, 3'd1, c);
                c = idleCtl();
                c.aluc = alu;
                if (k == K_BEQ || k == K_BNE) begin
                    c.pcsource = 3'd1;
                    c.wpc = (k == K_BEQ) ? z : !z;
                    push(2, 3'd2, c);
                end else if (k == K_LW || k == K_SW) begin
                    c.alusrcb = 2'd2;
                    push(2, 3'd2, c);
                    cw = idleCtl();
                    cw.mem_req = 1'b1; cw.iord = 1'b1; cw.wmem = (k == K_SW);
                    accessPhase(3'd3, mw, cw, cw, ok);
                    if (ok && k == K_LW) begin
                        c = idleCtl();
                        c.wreg = 1'b1; c.m2reg = 1'b1; c.regrt = 1'b1;
                        push(2, 3'd4, c);
                    end
                end else begin
                    c.shift = sh;
                    if (imm) c.alusrcb = 2'd2;
                    if (limm) c.sext = 1'b0;
                    push(2, 3'd2, c);
                    c = idleCtl();
                    c.wreg = 1'b1; c.regrt = imm;
                    push(2, 3'd4, c);
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] func,
                                 input logic z, input logic rdy);
        bus.op        = op;
        bus.func      = func;
        bus.z         = z;
        bus.mem_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
        end
    endtask

    // Replays the queued trace one clock per entry, sampling on the falling edge.
    task automatic drain(input logic [5:0] op, input logic [5:0] func, input logic z);
        int         r;
        logic [2:0] st;
        ctl_t       c;
        while (exp_st.size() > 0) begin
            r  = exp_rdy.pop_front();
            st = exp_st.pop_front();
            c  = exp_ctl.pop_front();
            applyStimulus(op, func, z, (r == 2) ? 1'($urandom_range(0, 1)) : r[0]);
            @(negedge clock);
            checkOutput("state", 32'(bus.state), 32'(st));
            checkOutput("ctl", 32'(actualCtl()), 32'(c));
            @(posedge clock);
            #1;
        end
    endtask

    task automatic runInstr(input logic [5:0] op, input logic [5:0] func, input logic z,
                            input int fw, input int mw);
        buildTrace(op, func, z, fw, mw);
        drain(op, func, z);
    endtask

    function automatic int pickWait();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6) return $urandom_range(0, 3);
        if (r == 7) return TIMEOUT;
        if (r == 8) return TIMEOUT + 1;
        return $urandom_range(4, TIMEOUT - 1);
    endfunction

    initial begin
        logic [11:0] enc;
        logic [5:0]  rop, rfunc;
        logic        rz;

        resetn = 1'b1;
        applyStimulus(6'b100011, 6'd0, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("reset_state", 32'(bus.state), 32'd0);
        checkOutput("reset_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("reset_ctl", 32'(actualCtl()), 32'(idleCtl()));
        @(posedge clock);
        #1;
        resetn = 1'b0;

        $display("[TB] add with memory always ready");
        runInstr(6'b000000, 6'b100000, 1'b0, 0, 0);

        $display("[TB] lw with fetch and data waits");
        runInstr(6'b100011, 6'd0, 1'b0, 3, 2);

        $display("[TB] sw data timeout, then fetch at the ready boundary");
        runInstr(6'b101011, 6'd0, 1'b0, 0, TIMEOUT + 1);
        runInstr(6'b101011, 6'd0, 1'b0, TIMEOUT, TIMEOUT);
        runInstr(6'b000000, 6'b100000, 1'b0, TIMEOUT + 1, 0);

        $display("[TB] undefined op and branches");
        runInstr(6'b111111, 6'd0, 1'b0, 0, 0);
        runInstr(6'b000100, 6'd0, 1'b0, 0, 0);
        runInstr(6'b000101, 6'd0, 1'b0, 0, 0);
        runInstr(6'b000100, 6'd0, 1'b1, 1, 0);

        $display("[TB] reset during a lw data wait");
        buildTrace(6'b100011, 6'd0, 1'b0, 0, TIMEOUT + 1);
        while (exp_st.size() > 5) begin
            void'(exp_rdy.pop_back());
            void'(exp_st.pop_back());
            void'(exp_ctl.pop_back());
        end
        drain(6'b100011, 6'd0, 1'b0);
        applyStimulus(6'b100011, 6'd0, 1'b0, 1'b0);
        resetn = 1'b1;
        @(negedge clock);
        checkOutput("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("midrst_ctl", 32'(actualCtl()), 32'(idleCtl()));
        @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midrst_state", 32'(bus.state), 32'd0);
        runInstr(6'b001101, 6'd0, 1'b0, 0, 0);

        $display("[TB] random instruction stream");
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 99) < 15) begin
                rop   = 6'($urandom);
                rfunc = 6'($urandom);
            end else begin
                enc   = LEGAL[$urandom_range(0, 23)];
                rop   = enc[11:6];
                rfunc = (rop == 6'd0) ? enc[5:0] : 6'($urandom);
            end
            rz = 1'($urandom_range(0, 1));
            runInstr(rop, rfunc, rz, pickWait(), pickWait());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
